run_sequencer: RTL and testbench
================================

RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50_000_000; the maximum number of clk cycles allowed in RUN before ERROR.
REQ-002 Parameter SYNC_STAGES, default 2; the depth of the key input synchronizer, minimum 2.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous and active-low.
REQ-005 clean_key  input  1  debounced push-button level; 0 = pressed, asynchronous to clk.
REQ-006 eng_start  output  1  one-cycle start pulse to the neural engine.
REQ-007 eng_done  input  1  one-cycle completion pulse from the engine.
REQ-008 eng_result  input  4  classified digit 0..9, valid in the cycle eng_done=1.
REQ-009 led  output  10  status/result display; led[i] is LED i.
REQ-010 busy  output  1  high while a run is outstanding (START or RUN).
REQ-011 error  output  1  high while in ERROR.

Function
REQ-012 clean_key shall pass through SYNC_STAGES flip-flops before use; a press event is a synchronized 1->0 transition.
REQ-013 FSM states: IDLE, START, RUN, SHOW, ERROR.
REQ-014 IDLE: a press event -> START; led = 10'b0000000001.
REQ-015 START: eng_start=1 for exactly one cycle, then unconditionally -> RUN; the timeout counter clears to 0.
REQ-016 RUN: the counter increments each cycle; eng_done=1 -> SHOW and captures eng_result into a 4-bit register the same edge.
REQ-017 RUN: counter == TIMEOUT_CYCLES-1 without eng_done -> ERROR; eng_done in that same cycle wins (-> SHOW).
REQ-018 Press events in START or RUN shall be ignored; no second eng_start is issued.
REQ-019 SHOW: led is one-hot at the captured digit (led[d]=1); a press event -> START (a new run).
REQ-020 A captured value of 10..15 shall go to ERROR instead of SHOW.
REQ-021 ERROR: led = 10'b1111111111; a press event -> IDLE.
REQ-022 eng_done outside RUN shall be ignored.
REQ-023 led during START and RUN = 10'b1000000001.
REQ-024 busy=1 in START and RUN only; error=1 in ERROR only.
REQ-025 The timeout counter shall be $clog2(TIMEOUT_CYCLES) bits wide and shall not wrap; it is only compared in RUN.
REQ-026 All outputs shall be registered; eng_start asserts the cycle after the press event is detected.

Reset
REQ-027 While reset_n=0: state=IDLE, eng_start=0, busy=0, error=0, led=10'b0000000001, counter=0, captured digit=0, synchronizer flops=1 (released).
REQ-028 Reset assertion mid-RUN shall abort immediately; no eng_start is issued on release.
REQ-029 A key held down through reset release shall not produce a press event.

Structure
REQ-030 A shared package shall hold the state enum, the LED constants (LED_IDLE, LED_BUSY, LED_ERROR) and the result width (4).
REQ-031 Sub-module key_sync (synchronizer + falling-edge detector, parameter SYNC_STAGES) is the only natural split.

Verification
REQ-032 Reset, press, with eng_done+eng_result=7 after 100 cycles -> exactly one eng_start pulse; led=10'b0010000000; busy falls.
REQ-033 TIMEOUT_CYCLES=16, press, no eng_done -> error=1 at cycle 16 of RUN; led=all ones; a further press -> IDLE, led=10'b0000000001.
REQ-034 Three presses during RUN, then eng_done with result 3 -> one eng_start total; led=10'b0000001000.
REQ-035 eng_done with eng_result=12 -> ERROR, error=1.
REQ-036 reset_n pulsed low mid-RUN with the key held low -> IDLE; no eng_start after release until a fresh release and press.
REQ-037 eng_done on the exact timeout cycle (result 0) -> SHOW, led=10'b0000000001, error stays 0.

Source files
------------

// File: rtl/run_sequencer_pkg.sv
// Shared types and constants for the run sequencer: state encoding, LED patterns,
// engine result width.
package run_sequencer_pkg;

    localparam int RES_W = 4;
    localparam int LED_W = 10;

    localparam logic [RES_W-1:0] MAX_DIGIT = 4'd9;

    localparam logic [LED_W-1:0] LED_IDLE  = 10'b0000000001;
    localparam logic [LED_W-1:0] LED_BUSY  = 10'b1000000001;
    localparam logic [LED_W-1:0] LED_ERROR = 10'b1111111111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_SHOW  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    // One-hot display of a digit; digits above 9 show nothing.
    function automatic logic [LED_W-1:0] led_onehot(input logic [RES_W-1:0] d);
        logic [LED_W-1:0] v;
        v = '0;
        if (d <= MAX_DIGIT) v = LED_W'(1) << d;
        return v;
    endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// Start/done handshake between the run sequencer (master) and the neural engine (slave).
interface run_sequencer_if;
    import run_sequencer_pkg::*;

    logic             eng_start;
    logic             eng_done;
    logic [RES_W-1:0] eng_result;

    modport master (output eng_start, input eng_done, input eng_result);
    modport slave  (input eng_start, output eng_done, output eng_result);

endinterface

// File: rtl/run_sequencer_key_sync.sv
// Key synchronizer and falling-edge (press) detector. Presses are only recognised
// once a genuine released level has been sampled after reset.
module key_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_i,
    output logic press_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   prev_q;
    logic                   armed_q;
    logic                   key_s;

    assign key_s = sync_q[SYNC_STAGES-1];

    // vld_q marks when sync output stops reflecting the reset value, so a key
    // held through reset release can never look like a 1->0 transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '1;
            vld_q   <= '0;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
            vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= key_s;
            if (vld_q[SYNC_STAGES-1] && key_s) armed_q <= 1'b1;
        end
    end

    assign press_o = armed_q & prev_q & ~key_s;

endmodule

// File: rtl/run_sequencer.sv
// Push-button driven run sequencer: starts the engine, waits for its result with a
// timeout, and shows the classified digit (or an error pattern) on the LEDs.
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clean_key,
    run_sequencer_if.master    eng,
    output logic [LED_W-1:0]   led,
    output logic               busy,
    output logic               error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RES_W-1:0] digit_q, digit_d;
    logic [LED_W-1:0] led_d;
    logic             press;

    key_sync #(.SYNC_STAGES(SYNC_STAGES)) u_key_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .key_i   (clean_key),
        .press_o (press)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        case (state_q)
            ST_IDLE:  if (press) state_d = ST_START;
            ST_START: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: begin
                if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
                // A completion on the last allowed cycle still beats the timeout.
                if (eng.eng_done) begin
                    digit_d = eng.eng_result;
                    state_d = (eng.eng_result > MAX_DIGIT) ? ST_ERROR : ST_SHOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERROR;
                end
            end
            ST_SHOW:  if (press) state_d = ST_START;
            ST_ERROR: if (press) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        led_d = LED_IDLE;
        case (state_d)
            ST_START, ST_RUN: led_d = LED_BUSY;
            ST_SHOW:          led_d = led_onehot(digit_d);
            ST_ERROR:         led_d = LED_ERROR;
            default:          led_d = LED_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            digit_q       <= '0;
            led           <= LED_IDLE;
            busy          <= 1'b0;
            error         <= 1'b0;
            eng.eng_start <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            led           <= led_d;
            busy          <= (state_d == ST_START) || (state_d == ST_RUN);
            error         <= (state_d == ST_ERROR);
            eng.eng_start <= (state_d == ST_START);
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized scoreboard bench for run_sequencer: each run's outcome is predicted from
// the completion cycle and result, and checked when busy (or error) falls.
module tb_run_sequencer;
    import run_sequencer_pkg::*;

    localparam int TMO  = 16;
    localparam int SYNC = 2;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             clean_key = 1'b1;
    logic [LED_W-1:0] led;
    logic             busy;
    logic             error;

    run_sequencer_if sif();

    run_sequencer #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clean_key (clean_key),
        .eng       (sif.master),
        .led       (led),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               clr;  // 1: expected end of ERROR (return to idle)
        logic [LED_W-1:0] led;
        bit               err;
        int               lat;  // cycles from eng_start sample to busy falling
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   starts_seen = 0;
    bit   model_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: counts start pulses and scores each run when busy or error drops.
    initial begin : mon
        bit   pb, pe;
        int   cyc, t0, nst;
        exp_t e;
        pb = 0; pe = 0; cyc = 0; t0 = 0; nst = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                pb = 0; pe = 0; nst = 0;
                continue;
            end
            if (sif.eng_start) begin
                nst++;
                starts_seen++;
                t0 = cyc;
            end
            if (pb && !busy) begin
                if (sbq.size() == 0) check("unexpected_run_end", 0, 1);
                else begin
                    e = sbq.pop_front();
                    check("run_end_kind", e.clr, 0);
                    check("run_led", led, e.led);
                    check("run_error", error, e.err);
                    check("run_latency", cyc - t0, e.lat);
                    check("run_starts", nst, 1);
                end
                nst = 0;
            end
            if (pe && !error) begin
                if (sbq.size() == 0) check("unexpected_err_clear", 0, 1);
                else begin
                    e = sbq.pop_front();
                    check("clear_kind", e.clr, 1);
                    check("clear_led", led, e.led);
                    check("clear_busy", busy, 0);
                end
            end
            pb = busy;
            pe = error;
        end
    end

    task automatic key_press();
        clean_key = 1'b0;
        repeat (4) @(negedge clk);
        clean_key = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_error();
        exp_t e;
        if (model_err) begin
            e.clr = 1; e.led = LED_IDLE; e.err = 0; e.lat = 0;
            sbq.push_back(e);
            key_press();
            model_err = 0;
        end
    endtask

    task automatic wait_start(output bit got);
        got = 0;
        for (int w = 0; w < 12 && !got; w++) begin
            @(negedge clk);
            if (sif.eng_start) got = 1;
        end
        check("eng_start_seen", got, 1);
    endtask

    // One run: press, engine completes in RUN cycle k with result r (k > TMO means
    // the pulse arrives after the timeout), optionally with extra presses in RUN.
    task automatic do_run(input int k, input logic [RES_W-1:0] r, input bit extra);
        exp_t e;
        bit   got;
        int   lim;
        clear_error();
        e.clr = 0;
        if (k <= TMO && r <= 9) begin
            e.led = LED_W'(1) << r; e.err = 0;
        end else begin
            e.led = LED_ERROR;      e.err = 1;
        end
        e.lat = ((k < TMO) ? k : TMO) + 1;
        sbq.push_back(e);
        clean_key = 1'b0;
        wait_start(got);
        lim = ((k < TMO) ? k : TMO) - 5;
        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            if (extra && j < lim) clean_key = (j % 2 == 1);
            else clean_key = 1'b1;
        end
        sif.eng_done = 1'b1;
        sif.eng_result = r;
        @(negedge clk);
        sif.eng_done = 1'b0;
        sif.eng_result = 4'($urandom_range(0, 15));
        for (int w = 0; w < 30 && busy; w++) @(negedge clk);
        check("busy_fell", busy, 0);
        model_err = e.err;
        repeat (2) @(negedge clk);
        if ($urandom_range(0, 2) == 0) begin
            sif.eng_done = 1'b1;
            sif.eng_result = 4'($urandom_range(0, 15));
            @(negedge clk);
            sif.eng_done = 1'b0;
            repeat (2) @(negedge clk);
            check("done_ignored_led", led, e.led);
            check("done_ignored_err", error, e.err);
        end
    endtask

    initial begin : stim
        bit               got;
        int               s0;
        int               k;
        logic [RES_W-1:0] r;
        sif.eng_done = 1'b0;
        sif.eng_result = '0;
        repeat (3) @(negedge clk);
        check("rst_led", led, LED_IDLE);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_eng_start", sif.eng_start, 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_led", led, LED_IDLE);
        check("idle_no_start", starts_seen, 0);

        do_run(10, 4'd7, 0);
        do_run(14, 4'd3, 1);
        do_run(16, 4'd0, 0);
        do_run(5, 4'd12, 0);
        do_run(17, 4'd4, 0);
        do_run(1, 4'd9, 0);
        do_run(20, 4'd2, 1);
        do_run(16, 4'd15, 0);

        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(1, 20);
            if ($urandom_range(0, 3) != 0) r = 4'($urandom_range(0, 9));
            else r = 4'($urandom_range(10, 15));
            do_run(k, r, $urandom_range(0, 1) == 1);
        end

        // Reset mid-run with the key held down through release.
        clear_error();
        clean_key = 1'b0;
        wait_start(got);
        repeat (3) @(negedge clk);
        check("busy_before_abort", busy, 1);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("abort_led", led, LED_IDLE);
        check("abort_busy", busy, 0);
        check("abort_error", error, 0);
        check("abort_eng_start", sif.eng_start, 0);
        s0 = starts_seen;
        #1 reset_n = 1'b1;
        repeat (25) @(negedge clk);
        check("held_key_no_start", starts_seen - s0, 0);
        check("held_key_busy", busy, 0);
        check("held_key_led", led, LED_IDLE);
        clean_key = 1'b1;
        repeat (6) @(negedge clk);
        do_run(9, 4'd5, 0);

        check("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
